jtag_host: RTL and testbench



---
 rtl/jtag_host_pkg.sv | 69 ++++++
 rtl/jtag_host_tck_gen.sv | 39 +++
 rtl/jtag_host.sv | 186 ++++++++++++++++++
 tb/tb_jtag_host.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_host_pkg.sv
// Shared JTAG host definitions: opcodes, TAP state encodings,
// instruction encodings and the TAP next-state function.
package jtag_host_pkg;

    localparam logic [1:0] OP_TLR      = 2'd0;
    localparam logic [1:0] OP_SHIFT_IR = 2'd1;
    localparam logic [1:0] OP_SHIFT_DR = 2'd2;
    localparam logic [1:0] OP_RSVD     = 2'd3;

    localparam int INST_REG_WIDTH_DEF = 4;

    localparam logic [INST_REG_WIDTH_DEF-1:0] E_EXTEST = 4'b0000;
    localparam logic [INST_REG_WIDTH_DEF-1:0] E_SAMPLE = 4'b0001;
    localparam logic [INST_REG_WIDTH_DEF-1:0] E_IDCODE = 4'b0010;
    localparam logic [INST_REG_WIDTH_DEF-1:0] E_BYPASS = 4'b1111;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR = 4'h0,
        TAP_EXIT1_DR = 4'h1,
        TAP_SHIFT_DR = 4'h2,
        TAP_PAUSE_DR = 4'h3,
        TAP_SEL_IR   = 4'h4,
        TAP_UPD_DR   = 4'h5,
        TAP_CAP_DR   = 4'h6,
        TAP_SEL_DR   = 4'h7,
        TAP_EXIT2_IR = 4'h8,
        TAP_EXIT1_IR = 4'h9,
        TAP_SHIFT_IR = 4'hA,
        TAP_PAUSE_IR = 4'hB,
        TAP_RTI      = 4'hC,
        TAP_UPD_IR   = 4'hD,
        TAP_CAP_IR   = 4'hE,
        TAP_TLR      = 4'hF
    } tap_state_t;

    typedef enum logic [2:0] {
        RESET_SEQ,
        IDLE,
        PRE,
        SHIFT,
        POST,
        RESP
    } host_state_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        unique case (s)
            TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
            default:      n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_host_tck_gen.sv
// TCK divider: CLK_DIV clks low then CLK_DIV clks high while enabled,
// with strobes marking the clk on which tck rises or falls.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic tl_reset,
    input  logic enable,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          wrap;

    assign wrap     = enable && (div_cnt == LAST);
    assign rise_stb = wrap && !tck;
    assign fall_stb = wrap && tck;

    always_ff @(posedge clk) begin
        if (!tl_reset) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            tck     <= ~tck;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/jtag_host.sv
// JTAG initiator: walks the target TAP through TLR, IR and DR scans
// from a command/response interface, returning captured TDO bits.
module jtag_host
    import jtag_host_pkg::*;
#(
    parameter int INST_REG_WIDTH = INST_REG_WIDTH_DEF,
    parameter int DR_MAX_WIDTH   = 32,
    parameter int CLK_DIV        = 2
) (
    input  logic                               clk,
    input  logic                               tl_reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [1:0]                         cmd_op,
    input  logic [INST_REG_WIDTH-1:0]          cmd_ir,
    input  logic [DR_MAX_WIDTH-1:0]            cmd_dr,
    input  logic [$clog2(DR_MAX_WIDTH+1)-1:0]  cmd_len,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [DR_MAX_WIDTH-1:0]            rsp_data,
    output logic                               tck,
    output logic                               tms,
    output logic                               tdi,
    input  logic                               tdo
);

    localparam int LW = $clog2(DR_MAX_WIDTH + 1);
    localparam int IW = (DR_MAX_WIDTH > 1) ? $clog2(DR_MAX_WIDTH) : 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(DR_MAX_WIDTH);
    localparam logic [LW-1:0] IR_LEN  = LW'(INST_REG_WIDTH);

    host_state_t             state;
    tap_state_t              tap;
    logic [2:0]              walk;
    logic [LW-1:0]           cnt;
    logic [LW-1:0]           cnt_nxt;
    logic [LW-1:0]           len;
    logic [LW-1:0]           len_dr;
    logic [DR_MAX_WIDTH-1:0] sh;
    logic                    is_ir;
    logic                    has_rsp;
    logic                    tck_en;
    logic                    rise_stb;
    logic                    fall_stb;

    assign tck_en  = state inside {RESET_SEQ, PRE, SHIFT, POST};
    assign cnt_nxt = cnt + LW'(1);

    always_comb begin
        len_dr = cmd_len;
        if (cmd_len == '0) len_dr = LW'(1);
        else if (cmd_len > MAX_LEN) len_dr = MAX_LEN;
    end

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .tl_reset (tl_reset),
        .enable   (tck_en),
        .tck      (tck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk) begin
        if (!tl_reset) begin
            state     <= RESET_SEQ;
            tap       <= TAP_TLR;
            walk      <= '0;
            cnt       <= '0;
            len       <= LW'(1);
            sh        <= '0;
            is_ir     <= 1'b0;
            has_rsp   <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (rise_stb) tap <= tap_next(tap, tms);
            unique case (state)
                RESET_SEQ: begin
                    if (fall_stb) begin
                        if (walk == 3'd5) begin
                            state <= RESP;
                        end else begin
                            walk <= walk + 3'd1;
                            tms  <= (walk < 3'd4);
                        end
                    end
                end
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rsp_data  <= '0;
                        walk      <= '0;
                        cnt       <= '0;
                        unique case (cmd_op)
                            OP_TLR: begin
                                state   <= RESET_SEQ;
                                has_rsp <= 1'b0;
                                tms     <= 1'b1;
                            end
                            OP_SHIFT_IR: begin
                                state   <= PRE;
                                has_rsp <= 1'b1;
                                is_ir   <= 1'b1;
                                sh      <= DR_MAX_WIDTH'(cmd_ir);
                                len     <= IR_LEN;
                                tms     <= 1'b1;
                            end
                            OP_SHIFT_DR: begin
                                state   <= PRE;
                                has_rsp <= 1'b1;
                                is_ir   <= 1'b0;
                                sh      <= cmd_dr;
                                len     <= len_dr;
                                tms     <= 1'b1;
                            end
                            default: begin
                                state   <= RESP;
                                has_rsp <= 1'b1;
                            end
                        endcase
                    end
                end
                PRE: begin
                    // IR walk is RTI->SelDR->SelIR->CapIR; DR skips SelIR
                    if (fall_stb) begin
                        if (walk == (is_ir ? 3'd3 : 3'd2)) begin
                            state <= SHIFT;
                            tms   <= (len == LW'(1));
                            tdi   <= sh[0];
                        end else begin
                            walk <= walk + 3'd1;
                            tms  <= is_ir && (walk == 3'd0);
                        end
                    end
                end
                SHIFT: begin
                    if (rise_stb) rsp_data[cnt[IW-1:0]] <= tdo;
                    if (fall_stb) begin
                        if (cnt_nxt == len) begin
                            state <= POST;
                            walk  <= '0;
                            tms   <= 1'b1;
                        end else begin
                            cnt <= cnt_nxt;
                            sh  <= sh >> 1;
                            tdi <= sh[1];
                            tms <= (cnt_nxt + LW'(1) == len);
                        end
                    end
                end
                POST: begin
                    if (fall_stb) begin
                        if (walk == 3'd0) begin
                            walk <= 3'd1;
                            tms  <= 1'b0;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_valid) begin
                        if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (has_rsp) begin
                        rsp_valid <= 1'b1;
                    end else begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= RESET_SEQ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: behavioural target TAP with IR, IDCODE and
// BYPASS registers, plus a response scoreboard.
module tb_jtag_host;
    import jtag_host_pkg::*;

    typedef logic lq_t[$];

    logic        clk;
    logic        tl_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_ir;
    logic [31:0] cmd_dr;
    logic [5:0]  cmd_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] sb_q[$];
    lq_t tms_log;
    lq_t tdi_log;

    localparam logic [31:0] IDCODE = 32'h1234_5679;

    tap_state_t  t_state = TAP_TLR;
    logic [3:0]  t_ir    = E_IDCODE;
    logic [3:0]  ir_sr   = 4'b0;
    logic [31:0] dr_sr   = 32'b0;
    logic [31:0] t_dr_last = 32'b0;

    jtag_host #(
        .INST_REG_WIDTH (4),
        .DR_MAX_WIDTH   (32),
        .CLK_DIV        (2)
    ) dut (
        .clk       (clk),
        .tl_reset  (tl_reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ir    (cmd_ir),
        .cmd_dr    (cmd_dr),
        .cmd_len   (cmd_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge tck) begin
        tms_log.push_back(tms);
        tdi_log.push_back(tdi);
        case (t_state)
            TAP_TLR:      t_ir <= E_IDCODE;
            TAP_CAP_IR:   ir_sr <= 4'b0001;
            TAP_SHIFT_IR: ir_sr <= {tdi, ir_sr[3:1]};
            TAP_UPD_IR:   t_ir <= ir_sr;
            TAP_CAP_DR:   dr_sr <= (t_ir == E_IDCODE) ? IDCODE : 32'h0;
            TAP_SHIFT_DR: dr_sr <= (t_ir == E_IDCODE) ? {tdi, dr_sr[31:1]} : {31'b0, tdi};
            TAP_UPD_DR:   t_dr_last <= dr_sr;
            default: ;
        endcase
        case (t_state)
            TAP_TLR:      t_state <= tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      t_state <= tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   t_state <= tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   t_state <= tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: t_state <= tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: t_state <= tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: t_state <= tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: t_state <= tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   t_state <= tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   t_state <= tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   t_state <= tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: t_state <= tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: t_state <= tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: t_state <= tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: t_state <= tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            default:      t_state <= tms ? TAP_SEL_DR   : TAP_RTI;
        endcase
    end

    always @(negedge tck) begin
        if (t_state == TAP_SHIFT_DR) tdo <= dr_sr[0];
        else if (t_state == TAP_SHIFT_IR) tdo <= ir_sr[0];
        else tdo <= 1'b0;
    end

    function automatic lq_t exp_scan(input bit is_ir, input int n);
        lq_t q;
        q.push_back(1'b1);
        if (is_ir) q.push_back(1'b1);
        q.push_back(1'b0);
        q.push_back(1'b0);
        for (int k = 0; k < n; k++) q.push_back(k == n - 1);
        q.push_back(1'b1);
        q.push_back(1'b0);
        return q;
    endfunction

    function automatic lq_t exp_tlr();
        lq_t q;
        for (int k = 0; k < 5; k++) q.push_back(1'b1);
        q.push_back(1'b0);
        return q;
    endfunction

    function automatic bit q_eq(input lq_t a, input lq_t b);
        if (a.size() != b.size()) return 1'b0;
        for (int i = 0; i < a.size(); i++)
            if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] q_pack(input lq_t a);
        logic [63:0] v = '0;
        for (int i = 0; i < a.size() && i < 64; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tms_log.delete();
        tdi_log.delete();
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] ir,
                         input logic [31:0] dr, input logic [5:0] len);
        int g = 0;
        while (cmd_ready !== 1'b1 && g < 2000) begin
            tick();
            g++;
        end
        if (cmd_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_op    = op;
        cmd_ir    = ir;
        cmd_dr    = dr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic ok, output int cycles);
        cycles = 0;
        while (rsp_valid !== 1'b1 && cycles < 2000) begin
            tick();
            cycles++;
        end
        ok = (rsp_valid === 1'b1);
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        tl_reset = 1'b0;
        repeat (3) tick();
        compared++;
        if ({tck, tms, tdi, cmd_ready, rsp_valid} !== 5'b01000 || rsp_data !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_values: tck/tms/tdi/rdy/vld=%b data=%h required 01000 data=0",
                     {tck, tms, tdi, cmd_ready, rsp_valid}, rsp_data);
        end
        clear_logs();
        tl_reset = 1'b1;
        // n counts clk edges from the first one that samples tl_reset high
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        compared++;
        if (n !== 25) begin
            mismatched++;
            $display("FAIL ready_latency: got %0d clks required 25", n);
        end
        compared++;
        if (!q_eq(tms_log, exp_tlr())) begin
            mismatched++;
            $display("FAIL startup_tms: got %0d bits %h required 6 bits %h",
                     tms_log.size(), q_pack(tms_log), q_pack(exp_tlr()));
        end
        tick();
        compared++;
        if (tck !== 1'b0 || tms !== 1'b0 || t_state !== TAP_RTI) begin
            mismatched++;
            $display("FAIL idle_lines: tck=%b tms=%b tap=%h required 0 0 %h",
                     tck, tms, t_state, TAP_RTI);
        end
    endtask

    task automatic test_shift_ir();
        logic ok;
        int cyc;
        logic [31:0] exp;
        logic [3:0] tdi_bits;
        clear_logs();
        issue(OP_SHIFT_IR, E_IDCODE, 32'h0, 6'd0);
        sb_q.push_back(32'h1);
        wait_rsp(ok, cyc);
        if (ok) begin
            exp = sb_q.pop_front();
            compared++;
            if (rsp_data !== exp) begin
                mismatched++;
                $display("FAIL ir_rsp: got %h required %h", rsp_data, exp);
            end
            compared++;
            if (cyc !== 41) begin
                mismatched++;
                $display("FAIL ir_latency: got %0d required 41", cyc);
            end
        end
        compared++;
        if (!q_eq(tms_log, exp_scan(1'b1, 4))) begin
            mismatched++;
            $display("FAIL ir_tms: got %0d bits %h required 10 bits %h",
                     tms_log.size(), q_pack(tms_log), q_pack(exp_scan(1'b1, 4)));
        end
        tdi_bits = {tdi_log[7], tdi_log[6], tdi_log[5], tdi_log[4]};
        compared++;
        if (tdi_bits !== E_IDCODE || t_ir !== E_IDCODE) begin
            mismatched++;
            $display("FAIL ir_tdi: tdi=%b target_ir=%b required %b", tdi_bits, t_ir, E_IDCODE);
        end
        consume();
    endtask

    task automatic test_shift_dr();
        logic ok;
        int cyc;
        logic [31:0] exp;
        logic [31:0] dr = 32'hA5C3_0F96;
        clear_logs();
        issue(OP_SHIFT_DR, 4'h0, dr, 6'd32);
        sb_q.push_back(IDCODE);
        wait_rsp(ok, cyc);
        if (ok) begin
            exp = sb_q.pop_front();
            compared++;
            if (rsp_data !== exp) begin
                mismatched++;
                $display("FAIL dr_rsp: got %h required %h", rsp_data, exp);
            end
            compared++;
            if (cyc !== 149) begin
                mismatched++;
                $display("FAIL dr_latency: got %0d required 149", cyc);
            end
        end
        compared++;
        if (!q_eq(tms_log, exp_scan(1'b0, 32))) begin
            mismatched++;
            $display("FAIL dr_tms: got %0d bits %h required 37 bits %h",
                     tms_log.size(), q_pack(tms_log), q_pack(exp_scan(1'b0, 32)));
        end
        compared++;
        if (t_dr_last !== dr) begin
            mismatched++;
            $display("FAIL dr_tdi: target got %h required %h", t_dr_last, dr);
        end
        consume();
    endtask

    task automatic test_bypass();
        logic ok;
        int cyc;
        logic [31:0] exp;
        logic [5:0] len;
        issue(OP_SHIFT_IR, E_BYPASS, 32'h0, 6'd0);
        sb_q.push_back(32'h1);
        wait_rsp(ok, cyc);
        if (ok) begin
            exp = sb_q.pop_front();
            compared++;
            if (rsp_data !== exp || t_ir !== E_BYPASS) begin
                mismatched++;
                $display("FAIL bypass_load: rsp=%h ir=%b required %h %b", rsp_data, t_ir, exp, E_BYPASS);
            end
        end
        consume();
        for (int i = 0; i < 2; i++) begin
            len = (i == 0) ? 6'd1 : 6'd0;
            clear_logs();
            issue(OP_SHIFT_DR, 4'h0, 32'hFFFF_FFFF, len);
            sb_q.push_back(32'h0);
            wait_rsp(ok, cyc);
            if (ok) begin
                exp = sb_q.pop_front();
                compared++;
                if (rsp_data !== exp) begin
                    mismatched++;
                    $display("FAIL bypass_len%0d_rsp: got %h required %h", len, rsp_data, exp);
                end
            end
            compared++;
            if (!q_eq(tms_log, exp_scan(1'b0, 1)) || t_dr_last !== 32'h1) begin
                mismatched++;
                $display("FAIL bypass_len%0d_tms: got %0d bits %h tgt=%h required 6 bits %h tgt=1",
                         len, tms_log.size(), q_pack(tms_log), t_dr_last, q_pack(exp_scan(1'b0, 1)));
            end
            consume();
        end
        clear_logs();
        issue(OP_SHIFT_DR, 4'h0, 32'h8000_0003, 6'd40);
        sb_q.push_back(32'h0000_0006);
        wait_rsp(ok, cyc);
        if (ok) begin
            exp = sb_q.pop_front();
            compared++;
            if (rsp_data !== exp) begin
                mismatched++;
                $display("FAIL clamp_rsp: got %h required %h", rsp_data, exp);
            end
        end
        compared++;
        if (tms_log.size() !== 37) begin
            mismatched++;
            $display("FAIL clamp_tck: got %0d tcks required 37", tms_log.size());
        end
        consume();
    endtask

    task automatic test_reserved();
        logic [31:0] exp;
        clear_logs();
        issue(OP_RSVD, 4'hF, 32'hDEAD_BEEF, 6'd7);
        sb_q.push_back(32'h0);
        compared++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL rsvd_accept: vld=%b rdy=%b required 0 0", rsp_valid, cmd_ready);
        end
        tick();
        exp = sb_q.pop_front();
        compared++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp || tms_log.size() !== 0) begin
            mismatched++;
            $display("FAIL rsvd_rsp: vld=%b data=%h tcks=%0d required 1 %h 0",
                     rsp_valid, rsp_data, tms_log.size(), exp);
        end
        consume();
    endtask

    task automatic test_back_to_back_hold();
        logic ok;
        int cyc;
        logic [31:0] exp;
        logic [31:0] snap;
        issue(OP_SHIFT_DR, 4'h0, 32'h0000_005A, 6'd8);
        sb_q.push_back(32'h0000_00B4);
        wait_rsp(ok, cyc);
        if (ok) begin
            exp = sb_q.pop_front();
            compared++;
            if (rsp_data !== exp) begin
                mismatched++;
                $display("FAIL hold_rsp: got %h required %h", rsp_data, exp);
            end
        end
        snap = exp;
        for (int c = 0; c < 10; c++) begin
            tick();
            compared++;
            if (rsp_valid !== 1'b1 || rsp_data !== snap || cmd_ready !== 1'b0 ||
                tck !== 1'b0 || tms !== 1'b0) begin
                mismatched++;
                $display("FAIL hold_clk%0d: vld=%b data=%h rdy=%b tck=%b tms=%b required 1 %h 0 0 0",
                         c, rsp_valid, rsp_data, cmd_ready, tck, tms, snap);
            end
        end
        consume();
        compared++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL hold_release: vld=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_scan();
        int g = 0;
        logic stale = 1'b0;
        clear_logs();
        issue(OP_SHIFT_DR, 4'h0, 32'h3C3C_A5A5, 6'd32);
        while (tms_log.size() < 14 && g < 1000) begin
            tick();
            g++;
        end
        tl_reset = 1'b0;
        tick();
        compared++;
        if (tck !== 1'b0 || tms !== 1'b1 || rsp_valid !== 1'b0 ||
            cmd_ready !== 1'b0 || rsp_data !== 32'h0) begin
            mismatched++;
            $display("FAIL midreset_values: tck=%b tms=%b vld=%b rdy=%b data=%h required 0 1 0 0 0",
                     tck, tms, rsp_valid, cmd_ready, rsp_data);
        end
        tick();
        clear_logs();
        tl_reset = 1'b1;
        g = 0;
        while (cmd_ready !== 1'b1 && g < 200) begin
            tick();
            g++;
            if (rsp_valid !== 1'b0) stale = 1'b1;
        end
        compared++;
        if (!q_eq(tms_log, exp_tlr()) || t_state !== TAP_RTI) begin
            mismatched++;
            $display("FAIL midreset_tlr: got %0d bits %h tap=%h required 6 bits %h tap=%h",
                     tms_log.size(), q_pack(tms_log), t_state, q_pack(exp_tlr()), TAP_RTI);
        end
        repeat (20) begin
            tick();
            if (rsp_valid !== 1'b0) stale = 1'b1;
        end
        compared++;
        if (stale !== 1'b0 || sb_q.size() !== 0) begin
            mismatched++;
            $display("FAIL midreset_stale: stale=%b pending=%0d required 0 0", stale, sb_q.size());
        end
    endtask

    initial begin
        tl_reset  = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_ir    = 4'h0;
        cmd_dr    = 32'h0;
        cmd_len   = 6'd0;
        rsp_ready = 1'b0;
        test_reset();
        test_shift_ir();
        test_shift_dr();
        test_bypass();
        test_reserved();
        test_back_to_back_hold();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
